spi_frame_engine: RTL and testbench
===================================

// Module: spi_frame_engine
// PURPOSE
//  SPI slave serial engine. Sits between the 2-stage input synchronizers and the config/status register bank.
//  Detects SCLK edges in clk domain per SPI mode; deserializes MOSI frames MSB-first: {RW, ADDR, DATA}.
//  Issues single-cycle register read/write strobes and serializes read data onto MISO.
// PARAMETERS
//  ADDR_WIDTH  7   address field width; frame bit 15 = RW (1=write, 0=read)
//  REG_WIDTH   8   data field width; FRAME_LEN = 1+ADDR_WIDTH+REG_WIDTH (16 at defaults)
// PORTS
//  clk        in   1           system clock; all logic single clock domain
//  rstb       in   1           reset, asynchronous assert, active-low
//  ena        in   1           clock enable; when low, all state holds
//  mode       in   2           {cpol,cpha}, already synchronized
//  spi_cs_n   in   1           chip select, active-low, already synchronized
//  spi_clk    in   1           SCLK, already synchronized
//  spi_mosi   in   1           MOSI, already synchronized
//  spi_miso   out  1           MISO data; tri-state control is outside this block
//  reg_addr   out  ADDR_WIDTH  address of current access, stable from rd/wr strobe until next frame
//  reg_wdata  out  REG_WIDTH   write data, valid with reg_wr
//  reg_wr     out  1           one-cycle write strobe
//  reg_rd     out  1           one-cycle read strobe
//  reg_rdata  in   REG_WIDTH   read data; bank returns it combinationally in the reg_rd cycle
//  frame_err  out  1           one-cycle pulse: cs_n deasserted mid-frame (1..FRAME_LEN-1 bits)
// BEHAVIOUR
//  Reset: spi_miso=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, frame_err=0, bit_cnt=0, state IDLE, sclk_q=0.
//  Edge detect: sclk_q <= spi_clk each enabled cycle; rise = spi_clk&~sclk_q; fall = ~spi_clk&sclk_q.
//  Mode latched on cs_n falling edge (mode_q); mode changes mid-frame are ignored.
//  Sample edge = (cpol^cpha) ? fall : rise; shift edge = the other one.
//  FSM states:
//   IDLE -> ADDR on cs_n falling edge; sclk_q is loaded with the current spi_clk there (no false edge).
//   ADDR -> DATA: on each sample edge, shift mosi into rx, bit_cnt++; leave after 1+ADDR_WIDTH bits.
//    On entry to DATA, reg_addr <= rx address field, latched the cycle after the last address sample.
//    If RW=0: reg_rd=1 that same cycle; tx <= reg_rdata.
//   DATA -> DONE after REG_WIDTH more sample bits.
//    On entry to DONE, if RW=1: reg_wr=1 for one cycle, reg_wdata <= rx data field.
//   DONE: further SCLK edges ignored; no second access until cs_n rises.
//   Any state -> IDLE when cs_n=1; frame_err pulses iff the state was ADDR/DATA with bit_cnt>0.
//   An aborted frame issues no reg_wr; an already-issued reg_rd is not retracted.
//  MISO:
//   cs_n=1 or ADDR state: spi_miso=0.
//   cpha=0: spi_miso=tx[MSB] from load cycle; tx shifts left on each shift edge in DATA.
//   cpha=1: spi_miso <= tx[MSB] and tx shifts left on each shift edge in DATA.
//   Last bit holds until cs_n rises; 0 is shifted into tx LSB.
//  Timing: SCLK half-period >= 4 clk cycles (2 sync + 1 edge det + 1 load margin).
//   Faster SCLK is unsupported; the only guarantee is no lockup once cs_n rises.
//  Strobes: reg_wr and reg_rd are never high in the same cycle and fire at most once per frame.
//  Simultaneous cs_n rise and sample edge: cs_n wins; the sample is discarded.
//  bit_cnt width = $clog2(FRAME_LEN+1); no wrap, saturates in DONE.
// STRUCTURE
//  Package spi_pkg: localparams FRAME_LEN, RW_BIT; typedef enum logic[1:0] {IDLE,ADDR,DATA,DONE} spi_state_t;
//   typedef struct {cpol,cpha} spi_mode_t.
//  Sub-module spi_edge_detect (sclk_q register, mode -> sample/shift pulse). Rest is flat in this module.
// TESTING
//  1 Mode 0, write 0x85 0x3C (RW=1,addr 0x05) -> one reg_wr, reg_addr=0x05, reg_wdata=0x3C, no reg_rd, frame_err=0.
//  2 Modes 0-3, read addr 0x00 with reg_rdata=0xCA -> one reg_rd; MISO bits 8..15 sampled by master = 0xCA.
//  3 Mode 3 write, cs_n raised after 10 bits -> frame_err pulses once; no reg_wr; next full frame works.
//  4 24-bit write frame -> exactly one reg_wr, using first 16 bits; extra 8 bits ignored.
//  5 rstb low mid-frame (after 12 bits) -> all outputs 0 asynchronously; after release, new full frame completes.
//  6 Toggle mode mid-frame (0->3) -> frame decoded with mode latched at cs_n fall; back-to-back frames with 4-cycle cs_n gap.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and default frame geometry for the SPI slave frame engine.
package spi_pkg;

    localparam int ADDR_WIDTH_DEF = 7;
    localparam int REG_WIDTH_DEF  = 8;
    localparam int FRAME_LEN      = 1 + ADDR_WIDTH_DEF + REG_WIDTH_DEF;
    localparam int RW_BIT         = FRAME_LEN - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_edge_detect.sv
// SCLK edge detector: turns the synchronized SCLK into single-cycle sample and
// shift pulses according to the latched {cpol,cpha}.
module spi_edge_detect (
    input  logic       clk,
    input  logic       rstb,
    input  logic       ena_i,
    input  logic       spi_clk_i,
    input  logic [1:0] mode_i,
    output logic       sample_o,
    output logic       shift_o
);

    logic sclk_q;
    logic rise_s;
    logic fall_s;

    // Previous SCLK level, refreshed every enabled cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sclk_q <= 1'b0;
        end else if (ena_i) begin
            sclk_q <= spi_clk_i;
        end else begin
            sclk_q <= sclk_q;
        end
    end

    // Edge decode; modes 1 and 2 sample on the falling edge.
    always_comb begin
        rise_s   = spi_clk_i & ~sclk_q;
        fall_s   = ~spi_clk_i & sclk_q;
        sample_o = 1'b0;
        shift_o  = 1'b0;
        if (ena_i) begin
            sample_o = (mode_i[1] ^ mode_i[0]) ? fall_s : rise_s;
            shift_o  = (mode_i[1] ^ mode_i[0]) ? rise_s : fall_s;
        end else begin
            sample_o = 1'b0;
            shift_o  = 1'b0;
        end
    end

endmodule

// File: rtl/spi_frame_engine.sv
// SPI slave frame engine: deserializes {RW, ADDR, DATA} frames, issues one
// register strobe per frame and serializes read data onto MISO.
module spi_frame_engine
    import spi_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int REG_WIDTH  = REG_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  ena,
    input  logic [1:0]            mode,
    input  logic                  spi_cs_n,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [REG_WIDTH-1:0]  reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [REG_WIDTH-1:0]  reg_rdata,
    output logic                  frame_err
);

    localparam int FLEN  = 1 + ADDR_WIDTH + REG_WIDTH;
    localparam int CNT_W = $clog2(FLEN + 1);
    localparam logic [CNT_W-1:0] ADDR_END  = CNT_W'(1 + ADDR_WIDTH);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FLEN);

    spi_state_t            state_q, state_d;
    spi_mode_t             mode_q, mode_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FLEN-1:0]       rx_q, rx_d;
    logic [REG_WIDTH-1:0]  tx_q, tx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic                  err_q, err_d;
    logic                  miso_q, miso_d;
    logic                  sample_s;
    logic                  shift_s;

    spi_edge_detect u_edge (
        .clk       (clk),
        .rstb      (rstb),
        .ena_i     (ena),
        .spi_clk_i (spi_clk),
        .mode_i    (mode_q),
        .sample_o  (sample_s),
        .shift_o   (shift_s)
    );

    // Frame sequencing, register strobes and MISO serializer.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        err_d     = 1'b0;
        miso_d    = miso_q;
        if (spi_cs_n) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            err_d     = ((state_q == ADDR) || (state_q == DATA)) && (bit_cnt_q != '0);
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ADDR;
                    mode_d    = spi_mode_t'(mode);
                    bit_cnt_d = '0;
                    rx_d      = '0;
                    tx_d      = '0;
                    miso_d    = 1'b0;
                end
                ADDR: begin
                    miso_d = 1'b0;
                    if (bit_cnt_q == ADDR_END) begin
                        state_d = DATA;
                        addr_d  = rx_q[ADDR_WIDTH-1:0];
                        rd_d    = ~rx_q[ADDR_WIDTH];
                    end else if (sample_s) begin
                        rx_d      = {rx_q[FLEN-2:0], spi_mosi};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
                        rx_d = rx_q;
                    end
                end
                DATA: begin
                    if (bit_cnt_q == FRAME_END) begin
                        state_d = DONE;
                        if (rx_q[FLEN-1]) begin
                            wr_d    = 1'b1;
                            wdata_d = rx_q[REG_WIDTH-1:0];
                        end else begin
                            wr_d = 1'b0;
                        end
                    end else if (sample_s) begin
                        rx_d      = {rx_q[FLEN-2:0], spi_mosi};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
                        rx_d = rx_q;
                    end
                    // With cpha=0 the first data bit is already on MISO at load,
                    // so the shift edge before the first data sample is skipped.
                    if (rd_q) begin
                        tx_d   = reg_rdata;
                        miso_d = mode_q.cpha ? miso_q : reg_rdata[REG_WIDTH-1];
                    end else if (shift_s && (mode_q.cpha || (bit_cnt_q > ADDR_END))) begin
                        tx_d   = {tx_q[REG_WIDTH-2:0], 1'b0};
                        miso_d = mode_q.cpha ? tx_q[REG_WIDTH-1] : tx_q[REG_WIDTH-2];
                    end else begin
                        tx_d = tx_q;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers; pulse outputs are forced low while the enable is off.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
            miso_q    <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
            miso_q    <= miso_d;
        end else begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            err_q <= 1'b0;
        end
    end

    assign spi_miso  = miso_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = wr_q;
    assign reg_rd    = rd_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_spi_frame_engine.sv
// Directed bench for spi_frame_engine: a table of SPI master frames with
// hand-computed register accesses, plus an asynchronous-reset sequence.
module tb_spi_frame_engine;

    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rstb = 1'b1;
    logic       ena;
    logic [1:0] mode;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       frame_err;
    logic [7:0] cur_rdata;

    int checks = 0;
    int failures = 0;
    int n_wr = 0;
    int n_rd = 0;
    int n_err = 0;
    int n_both = 0;
    logic [6:0] cap_addr_wr = 7'h00;
    logic [6:0] cap_addr_rd = 7'h00;
    logic [7:0] cap_wdata = 8'h00;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] bits;
        int          nbits;
        int          tog_at;
        logic [1:0]  tog_mode;
        logic [7:0]  rdata;
        int          gap;
        logic        hold_cs;
        int          exp_wr;
        int          exp_rd;
        int          exp_err;
        logic [6:0]  exp_addr;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_miso;
    } vec_t;

    vec_t vecs [15];

    spi_frame_engine dut (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .mode      (mode),
        .spi_cs_n  (spi_cs_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Register bank answers only in the read-strobe cycle.
    assign reg_rdata = reg_rd ? cur_rdata : 8'h00;

    always @(negedge clk) begin
        if (rstb) begin
            if (reg_wr) begin
                n_wr      <= n_wr + 1;
                cap_addr_wr <= reg_addr;
                cap_wdata <= reg_wdata;
            end
            if (reg_rd) begin
                n_rd        <= n_rd + 1;
                cap_addr_rd <= reg_addr;
            end
            if (frame_err) n_err <= n_err + 1;
            if (reg_wr && reg_rd) n_both <= n_both + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit-banged SPI master; returns MISO as sampled at each sample edge.
    task automatic run_frame(input vec_t v, output logic [31:0] mb);
        mb        = 32'h0;
        mode      = v.mode;
        cur_rdata = v.rdata;
        spi_clk   = v.mode[1];
        spi_cs_n  = 1'b0;
        tick(H);
        for (int i = 0; i < v.nbits; i++) begin
            if (i == v.tog_at) mode = v.tog_mode;
            if (!v.mode[0]) begin
                spi_mosi = v.bits[31-i];
                tick(H);
                mb[31-i] = spi_miso;
                spi_clk  = ~spi_clk;
                tick(H);
                spi_clk  = ~spi_clk;
            end else begin
                spi_clk  = ~spi_clk;
                spi_mosi = v.bits[31-i];
                tick(H);
                mb[31-i] = spi_miso;
                spi_clk  = ~spi_clk;
                tick(H);
            end
        end
        if (!v.hold_cs) begin
            tick(H);
            spi_cs_n = 1'b1;
            tick(v.gap);
        end
    endtask

    task automatic check_frame(input string tag, input vec_t v, input logic [31:0] mb,
                               input int b_wr, input int b_rd, input int b_err);
        chk({tag, "_wr_count"}, 32'(n_wr - b_wr), 32'(v.exp_wr));
        chk({tag, "_rd_count"}, 32'(n_rd - b_rd), 32'(v.exp_rd));
        chk({tag, "_err_count"}, 32'(n_err - b_err), 32'(v.exp_err));
        if (v.exp_wr > 0) begin
            chk({tag, "_wr_addr"}, 32'(cap_addr_wr), 32'(v.exp_addr));
            chk({tag, "_wdata"}, 32'(cap_wdata), 32'(v.exp_wdata));
        end
        if (v.exp_rd > 0) begin
            chk({tag, "_rd_addr"}, 32'(cap_addr_rd), 32'(v.exp_addr));
            chk({tag, "_miso"}, 32'(mb[23:16]), 32'(v.exp_miso));
        end
        if ((v.exp_wr > 0) || (v.exp_rd > 0)) begin
            chk({tag, "_addr_hold"}, 32'(reg_addr), 32'(v.exp_addr));
        end
    endtask

    initial begin
        logic [31:0] mb;
        int b_wr, b_rd, b_err;
        vec_t v;

        ena = 1'b1; mode = 2'd0; spi_cs_n = 1'b1; spi_clk = 1'b0;
        spi_mosi = 1'b0; cur_rdata = 8'h00;
        #1 rstb = 1'b0;
        tick(3);
        chk("rst_miso", 32'(spi_miso), 32'h0);
        chk("rst_addr", 32'(reg_addr), 32'h0);
        chk("rst_wdata", 32'(reg_wdata), 32'h0);
        chk("rst_wr", 32'(reg_wr), 32'h0);
        chk("rst_rd", 32'(reg_rd), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        rstb = 1'b1;
        tick(3);

        //            mode  bits            n   tog  tm    rdata  gap hold wr rd er addr   wdata  miso
        vecs[0]  = '{2'd0, 32'h853C_0000, 16, -1, 2'd0, 8'h00, 6, 1'b0, 1, 0, 0, 7'h05, 8'h3C, 8'h00};
        vecs[1]  = '{2'd0, 32'h0000_0000, 16, -1, 2'd0, 8'hCA, 6, 1'b0, 0, 1, 0, 7'h00, 8'h00, 8'hCA};
        vecs[2]  = '{2'd1, 32'h0000_0000, 16, -1, 2'd0, 8'hCA, 6, 1'b0, 0, 1, 0, 7'h00, 8'h00, 8'hCA};
        vecs[3]  = '{2'd2, 32'h0000_0000, 16, -1, 2'd0, 8'hCA, 6, 1'b0, 0, 1, 0, 7'h00, 8'h00, 8'hCA};
        vecs[4]  = '{2'd3, 32'h0000_0000, 16, -1, 2'd0, 8'hCA, 6, 1'b0, 0, 1, 0, 7'h00, 8'h00, 8'hCA};
        vecs[5]  = '{2'd3, 32'h853C_0000, 10, -1, 2'd0, 8'h00, 6, 1'b0, 0, 0, 1, 7'h00, 8'h00, 8'h00};
        vecs[6]  = '{2'd3, 32'h9142_0000, 16, -1, 2'd0, 8'h00, 6, 1'b0, 1, 0, 0, 7'h11, 8'h42, 8'h00};
        vecs[7]  = '{2'd0, 32'h853C_FF00, 24, -1, 2'd0, 8'h00, 6, 1'b0, 1, 0, 0, 7'h05, 8'h3C, 8'h00};
        vecs[8]  = '{2'd2, 32'h7F00_0000, 16, -1, 2'd0, 8'h81, 6, 1'b0, 0, 1, 0, 7'h7F, 8'h00, 8'h81};
        vecs[9]  = '{2'd1, 32'hFFA5_0000, 16, -1, 2'd0, 8'h00, 6, 1'b0, 1, 0, 0, 7'h7F, 8'hA5, 8'h00};
        vecs[10] = '{2'd0, 32'h0000_0000,  0, -1, 2'd0, 8'h00, 6, 1'b0, 0, 0, 0, 7'h00, 8'h00, 8'h00};
        vecs[11] = '{2'd0, 32'h853C_0000, 15, -1, 2'd0, 8'h00, 6, 1'b0, 0, 0, 1, 7'h00, 8'h00, 8'h00};
        vecs[12] = '{2'd1, 32'h1200_0000, 12, -1, 2'd0, 8'h77, 6, 1'b0, 0, 1, 1, 7'h12, 8'h00, 8'h70};
        vecs[13] = '{2'd0, 32'h3300_0000, 16,  4, 2'd3, 8'h5E, 4, 1'b0, 0, 1, 0, 7'h33, 8'h00, 8'h5E};
        vecs[14] = '{2'd3, 32'hB3C7_0000, 16, -1, 2'd0, 8'h00, 4, 1'b0, 1, 0, 0, 7'h33, 8'hC7, 8'h00};

        for (int k = 0; k < 15; k++) begin
            b_wr = n_wr; b_rd = n_rd; b_err = n_err;
            run_frame(vecs[k], mb);
            check_frame($sformatf("vec%0d", k), vecs[k], mb, b_wr, b_rd, b_err);
        end

        // Asynchronous reset in the middle of a mode-1 read frame.
        v = '{2'd1, 32'h2A00_0000, 12, -1, 2'd0, 8'hF0, 6, 1'b1, 0, 1, 0, 7'h2A, 8'h00, 8'h00};
        b_rd = n_rd;
        run_frame(v, mb);
        chk("pre_rst_rd_count", 32'(n_rd - b_rd), 32'h1);
        chk("pre_rst_addr", 32'(reg_addr), 32'h2A);
        chk("pre_rst_miso", 32'(spi_miso), 32'h1);
        #2 rstb = 1'b0;
        #1;
        chk("async_rst_miso", 32'(spi_miso), 32'h0);
        chk("async_rst_addr", 32'(reg_addr), 32'h0);
        chk("async_rst_wdata", 32'(reg_wdata), 32'h0);
        chk("async_rst_strobes", 32'({reg_wr, reg_rd, frame_err}), 32'h0);
        spi_cs_n = 1'b1;
        tick(2);
        rstb = 1'b1;
        tick(2);
        v = '{2'd1, 32'hAA55_0000, 16, -1, 2'd0, 8'h00, 6, 1'b0, 1, 0, 0, 7'h2A, 8'h55, 8'h00};
        b_wr = n_wr; b_rd = n_rd; b_err = n_err;
        run_frame(v, mb);
        check_frame("post_rst", v, mb, b_wr, b_rd, b_err);

        chk("wr_rd_overlap", 32'(n_both), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
